serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flop and shift
// registers process one operand bit per clock, LSB first, behind start/done.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             c_r;
  logic [CW-1:0]    count_r;
  logic             fa_sum_s;
  logic             fa_co_s;
  logic             last_s;

  assign fa_sum_s = a_sh_r[0] ^ b_sh_r[0] ^ c_r;
  assign fa_co_s  = (a_sh_r[0] & b_sh_r[0]) | (a_sh_r[0] & c_r) | (b_sh_r[0] & c_r);
  assign last_s   = (count_r == CW'(WIDTH - 1));

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake outputs registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s != IDLE);
      done <= (state_nxt_s == DONE);
    end
  end

  // Operand/sum shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      c_r      <= 1'b0;
      count_r  <= {CW{1'b0}};
      sum      <= {WIDTH{1'b0}};
      carry    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            c_r      <= cin;
            sum_sh_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          c_r      <= fa_co_s;
          sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
          count_r  <= count_r + CW'(1);
          // Results are published on the edge that retires the last bit.
          if (last_s) begin
            sum   <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
            carry <= fa_co_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios, exhaustive sweep
// and random operations against an arithmetic a+b+cin reference.
module tb_serial_adder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_sum = '0;
  logic         exp_carry = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    logic [W:0] ref_v;
    int lat;
    int busy_n;
    logic held;
    ref_v = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; busy_n = 0; held = 1'b1;
    while (done !== 1'b1 && lat < W + 4) begin
      if (busy === 1'b1) busy_n++;
      if (sum !== exp_sum || carry !== exp_carry) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) busy_n++;
    check("latency", 32'(lat), 32'(W));
    check("held_between", 32'(held), 32'd1);
    check("sum", 32'(sum), 32'(ref_v[W-1:0]));
    check("carry", 32'(carry), 32'(ref_v[W]));
    check("busy_cycles", 32'(busy_n), 32'(W + 1));
    exp_sum = ref_v[W-1:0];
    exp_carry = ref_v[W];
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int first_idx;
    int last_idx;
    logic spacing_ok;
    logic no_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd5, 4'd2, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd9, 4'd7, 1'b1);

    // A start pulse during RUN must be ignored.
    @(negedge clk);
    a = 4'd3; b = 4'd3; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd8; b = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2 * (W + 2) + 4; i++) begin
      if (done === 1'b1) begin
        ndone++;
        check("ignored_sum", 32'(sum), 32'd6);
      end
      @(negedge clk);
    end
    check("ignored_done_count", 32'(ndone), 32'd1);
    check("ignored_busy", 32'(busy), 32'd0);
    exp_sum = 4'd6; exp_carry = 1'b0;

    // Held start: back-to-back operations every W+2 cycles.
    a = 4'd4; b = 4'd4; cin = 1'b0; start = 1'b1;
    ndone = 0; first_idx = -1; last_idx = -1; spacing_ok = 1'b1;
    for (int i = 1; i <= 3 * (W + 2); i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (first_idx < 0) first_idx = i;
        else if (i - last_idx != W + 2) spacing_ok = 1'b0;
        last_idx = i;
        check("b2b_sum", 32'(sum), 32'd8);
        check("b2b_carry", 32'(carry), 32'd0);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    check("b2b_first", 32'(first_idx), 32'(W + 1));
    check("b2b_spacing", 32'(spacing_ok), 32'd1);
    exp_sum = 4'd8; exp_carry = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset two cycles into an operation.
    a = 4'd7; b = 4'd6; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    no_done = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);
    rst_n = 1'b1;
    exp_sum = '0; exp_carry = 1'b0;
    run_op(4'd0, 4'd0, 1'b1);

    // Exhaustive sweep of all operand/carry-in combinations.
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      run_op(W'(i >> (W + 1)), W'(i >> 1), 1'(i));
    end

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
